// File: rtl/qn17_pkg.sv
// qn17_pkg: shared constants, readout word formats and FSM encoding for tube_event_builder.
// Contents: channel count/bases, tag codes, field widths, state_t, word-packing helpers.
// Build option: EVENT_TRAILER_EN adds the TRAILER state and the trailer word helper.
package qn17_pkg;

    localparam int NCH     = 32;
    localparam int BASE_3A = 0;
    localparam int BASE_3B = 8;
    localparam int BASE_4A = 16;
    localparam int BASE_4B = 24;
    localparam int TW      = 10;
    localparam int CW      = 5;
    localparam int EW      = 14;

    localparam logic [1:0] TAG_HDR = 2'b00;
    localparam logic [1:0] TAG_TRL = 2'b01;
    localparam logic       TAG_HIT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WINDOW,
        S_HEADER,
        S_SCAN
`ifdef EVENT_TRAILER_EN
        , S_TRAILER
`endif
    } state_t;

    function automatic logic [15:0] hdr_word(input logic [EW-1:0] evt);
        return {TAG_HDR, evt};
    endfunction

    function automatic logic [15:0] hit_word(input logic [CW-1:0] ch, input logic [TW-1:0] t);
        return {TAG_HIT, ch, t};
    endfunction

    function automatic logic [15:0] trl_word(input logic [5:0] nhits);
        return {TAG_TRL, 8'h00, nhits};
    endfunction

endpackage

// File: rtl/tube_sync_edge.sv
// tube_sync_edge: W-bit multi-flop synchroniser followed by a one-cycle rising-edge pulse.
// Ports: clk, rst_n (async active-low), i_d (async inputs), o_rise (synchronised 0->1 pulse).
module tube_sync_edge #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_sync [STAGES];
    logic [W-1:0] r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) r_sync[k] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/tube_event_builder.sv
// tube_event_builder: opens a timed window per scintillator coincidence, timestamps the first
// edge on each of 32 tube channels, then writes a header plus one word per hit into a FIFO.
// Ports: clk100, rst_n (async active-low), SCIN_COIN, TUBE3A/3B/4A/4B (async inputs),
//        wr_data/wr_en/wr_full (FIFO write port), busy (not IDLE), dropLight (sticky drop flag).
// Build option: EVENT_TRAILER_EN appends a trailer word {2'b01, 8'h00, nhits} after the scan.
module tube_event_builder
    import qn17_pkg::*;
#(
    parameter int WINDOW_CYCLES = 100,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk100,
    input  logic        rst_n,
    input  logic        SCIN_COIN,
    input  logic [7:0]  TUBE3A,
    input  logic [7:0]  TUBE3B,
    input  logic [7:0]  TUBE4A,
    input  logic [7:0]  TUBE4B,
    output logic [15:0] wr_data,
    output logic        wr_en,
    input  logic        wr_full,
    output logic        busy,
    output logic        dropLight
);

    localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);

    logic [NCH-1:0]         w_tube;
    logic [NCH-1:0]         w_hit;
    logic                   w_coin;
    state_t                 r_state;
    state_t                 w_next;
    logic [TW-1:0]          r_t;
    logic [CW-1:0]          r_idx;
    logic [NCH-1:0]         r_flag;
    logic [NCH-1:0][TW-1:0] r_time;
    logic [EW-1:0]          r_evt;
    logic                   r_drop;
    logic                   w_pend;
    logic                   w_step;
    logic [15:0]            w_word;

    assign w_tube[BASE_3A +: 8] = TUBE3A;
    assign w_tube[BASE_3B +: 8] = TUBE3B;
    assign w_tube[BASE_4A +: 8] = TUBE4A;
    assign w_tube[BASE_4B +: 8] = TUBE4B;

    tube_sync_edge #(.W(NCH), .STAGES(SYNC_STAGES)) u_sync_tube (
        .clk    (clk100),
        .rst_n  (rst_n),
        .i_d    (w_tube),
        .o_rise (w_hit)
    );

    tube_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync_coin (
        .clk    (clk100),
        .rst_n  (rst_n),
        .i_d    (SCIN_COIN),
        .o_rise (w_coin)
    );

    // A state with no pending word always advances; a pending word advances only once written.
    assign w_step = !w_pend || !wr_full;

    always_comb begin
        w_next = r_state;
        w_pend = 1'b0;
        w_word = '0;
        case (r_state)
            S_IDLE:   w_next = w_coin ? S_WINDOW : S_IDLE;
            S_WINDOW: w_next = (r_t == T_LAST) ? S_HEADER : S_WINDOW;
            S_HEADER: begin
                w_pend = 1'b1;
                w_word = hdr_word(r_evt);
                w_next = w_step ? S_SCAN : S_HEADER;
            end
            S_SCAN: begin
                w_pend = r_flag[r_idx];
                w_word = w_pend ? hit_word(r_idx, r_time[r_idx]) : '0;
`ifdef EVENT_TRAILER_EN
                w_next = (w_step && r_idx == CW'(NCH - 1)) ? S_TRAILER : S_SCAN;
`else
                w_next = (w_step && r_idx == CW'(NCH - 1)) ? S_IDLE : S_SCAN;
`endif
            end
`ifdef EVENT_TRAILER_EN
            S_TRAILER: begin
                w_pend = 1'b1;
                w_word = trl_word(6'($countones(r_flag)));
                w_next = w_step ? S_IDLE : S_TRAILER;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_idx   <= '0;
            r_flag  <= '0;
            r_time  <= '0;
            r_evt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_coin && r_state != S_IDLE) r_drop <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_t <= '0;
                    if (w_coin) r_flag <= '0;
                end
                S_WINDOW: begin
                    r_t <= r_t + 1'b1;
                    for (int c = 0; c < NCH; c++) begin
                        if (w_hit[c] && !r_flag[c]) begin
                            r_flag[c] <= 1'b1;
                            r_time[c] <= r_t;
                        end
                    end
                end
                S_HEADER: begin
                    r_idx <= '0;
                    if (w_step) r_evt <= r_evt + 1'b1;
                end
                S_SCAN: if (w_step) r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign wr_en     = w_pend && !wr_full;
    assign wr_data   = w_word;
    assign busy      = (r_state != S_IDLE);
    assign dropLight = r_drop;

endmodule
